arduino_note_rx: RTL
====================

// Module: arduino_note_rx
// PURPOSE
// - Receiver for note codes sent by the external Arduino (pitch/spectrum front-end) over a 3-bit code + valid link.
// - Complements the FPGA->Arduino note output path.
// - Synchronizes and debounces the asynchronous link, then validates the code.
// - Outputs a one-hot 7-bit vector that drops directly into the game datapath's `botoes` input,
//   plus a one-cycle `jogada` pulse per accepted note.
// PARAMETERS
// - STABLE_CYCLES  50000   cycles code+valid must stay unchanged before acceptance (1 ms @ 50 MHz)
// - HOLD_CYCLES    250000  cycles botoes stays asserted after acceptance (5 ms @ 50 MHz)
// - CNT_W          20      shared counter width; must satisfy 2**CNT_W > max(STABLE_CYCLES, HOLD_CYCLES)
// PORTS
// - clock        in   1  system clock, single clock domain
// - reset        in   1  synchronous, active-low reset
// - enable       in   1  from control unit; 0 forces IDLE
// - ard_code     in   3  note code from Arduino, asynchronous; 0 = no note, 1..7 = notes
// - ard_valid    in   1  code-valid level from Arduino, asynchronous
// - botoes       out  7  one-hot accepted note
// - jogada       out  1  one-cycle pulse on note acceptance
// - erro_codigo  out  1  one-cycle pulse when a stable valid carries code 0
// - db_code      out  3  last accepted code (debug)
// - db_estado    out  3  FSM state encoding (debug)
// BEHAVIOUR
// - Reset (reset==0 at a clock edge):
//   - state=IDLE; counter=0; synchronizers cleared.
//   - botoes=0, jogada=0, erro_codigo=0, db_code=0.
//   - Reset mid-operation aborts any state on that edge.
// - Sync: ard_code and ard_valid each pass a 2-FF synchronizer. All logic below uses synced values (sc, sv).
// - FSM states and encodings:
//   - IDLE=0: sv&enable -> QUALIFY; latch sc into code_r; counter=0.
//   - QUALIFY=1: sv==0 -> IDLE, no output.
//     - sc!=code_r -> code_r=sc, counter=0.
//     - counter==STABLE_CYCLES-1 -> EMIT if code_r!=0, else ERRO.
//     - otherwise counter++.
//   - EMIT=2: one cycle.
//     - jogada=1; botoes=onehot(code_r); db_code=code_r.
//     - Next: HOLD with counter=0.
//   - HOLD=3: botoes held; counter++.
//     - At HOLD_CYCLES-1 -> RELEASE.
//     - sv/sc changes are ignored.
//   - RELEASE=4: botoes=0; stay until sv==0, then IDLE.
//     - One valid assertion never yields two notes.
//   - ERRO=5: erro_codigo=1 for one cycle; botoes=0 -> RELEASE.
// - onehot: code k in 1..7 -> botoes[k-1]=1, all other bits 0.
// - Latency: valid/code change to jogada = 2 (sync) + 1 (IDLE) + STABLE_CYCLES + 1 edges.
//   - botoes rises in the same cycle as jogada.
// - Any state with enable==0 -> IDLE next edge.
//   - botoes/jogada/erro_codigo go to 0; db_code is kept.
//   - enable==0 and reset==0 at the same edge: reset wins (identical result, plus db_code=0).
// - Counter saturates logically by state exit; no wrap is reachable.
// CONFIGURATION
// - Macro ARDUINO_ACK_EN.
// - Defined:
//   - Adds output `ard_ack` (1 bit, reset 0), giving a 4-phase handshake.
//   - ard_ack=1 from EMIT or ERRO entry through RELEASE; it clears on the edge leaving RELEASE (sv==0).
// - Undefined: port and logic absent; the Arduino must use a free-running protocol.
// STRUCTURE
// - Include file arduino_rx_defs.vh:
//   - state localparams (IDLE..ERRO);
//   - NOTE_NONE=3'd0;
//   - onehot7 function (code -> 7-bit vector).
// - Sub-module sync_2ff (parameter W): instanced once with W=4 for {ard_valid, ard_code}.
// - Remaining FSM, counter and output registers live in this module.
// TESTING (bench uses STABLE_CYCLES=4, HOLD_CYCLES=8, enable=1 unless stated)
// - Reset: hold reset=0 for 2 cycles with ard_valid=1.
//   -> botoes=0, jogada=0, erro_codigo=0, db_code=0, db_estado=0 throughout.
// - Accept code 5: ard_code=5, ard_valid=1 held.
//   -> exactly one jogada pulse 8 edges after the input change;
//   -> botoes=7'b0010000 for 9 cycles (EMIT+HOLD), then 0; db_code=5.
// - Glitch: code 5 then 2 at the 2nd QUALIFY cycle.
//   -> counter restarts; accepted note is 2; botoes=7'b0000010; no pulse for code 5.
// - Invalid: ard_code=0, ard_valid=1 held.
//   -> erro_codigo high 1 cycle; jogada never pulses; botoes stays 0; state parks in RELEASE (4).
// - Long valid: ard_valid=1 for 40 cycles, then 0 for 3, then 1 again.
//   -> exactly two jogada pulses total.
//   -> with ARDUINO_ACK_EN, ard_ack falls 1 edge after synced valid low.
// - Abort: enable=0 during HOLD -> botoes=0 next edge, db_estado=0, db_code kept.
//   - reset=0 during QUALIFY -> IDLE next edge, no jogada.

Source files
------------

// File: rtl/arduino_note_rx_pkg.sv
// Shared definitions for the Arduino note receiver: FSM state encodings,
// the "no note" code and the code-to-one-hot helper.
package arduino_note_rx_pkg;

    // Encodings are visible on db_estado, so they are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUALIFY = 3'd1,
        ST_EMIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_ERRO    = 3'd5
    } state_t;

    localparam logic [2:0] NOTE_NONE = 3'd0;

    // Code k in 1..7 maps to bit k-1; code 0 maps to an all-zero vector.
    function automatic logic [6:0] onehot7(input logic [2:0] code);
        logic [7:0] t;
        t = 8'd1 << code;
        return t[7:1];
    endfunction

endpackage

// File: rtl/arduino_note_rx_sync_2ff.sv
// Two-flop synchronizer for a W-bit bundle of asynchronous levels.
// Bits are synchronized independently; the consumer tolerates skew between
// bits because it waits for the bundle to be stable before acting on it.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            logic meta_q;
            logic sync_q;

            // First stage may go metastable; second stage gives it a cycle to settle.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta_q <= d_i[gi];
                    sync_q <= meta_q;
                end
            end

            assign q_o[gi] = sync_q;
        end
    endgenerate

endmodule

// File: rtl/arduino_note_rx.sv
// Receiver for 3-bit note codes from the Arduino front-end.
// Synchronizes {valid, code}, waits for STABLE_CYCLES of an unchanged code,
// then emits a one-hot note on botoes for EMIT+HOLD cycles with a single
// jogada pulse. A stable valid carrying code 0 pulses erro_codigo instead.
// Optional feature macro: ARDUINO_ACK_EN adds the ard_ack handshake output.
module arduino_note_rx
    import arduino_note_rx_pkg::*;
#(
    parameter int STABLE_CYCLES = 50000,
    parameter int HOLD_CYCLES   = 250000,
    parameter int CNT_W         = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] ard_code,
    input  logic       ard_valid,
    output logic [6:0] botoes,
    output logic       jogada,
    output logic       erro_codigo,
    output logic [2:0] db_code,
    output logic [2:0] db_estado
`ifdef ARDUINO_ACK_EN
    ,
    output logic       ard_ack
`endif
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [3:0]       sync_out;
    logic             sv;
    logic [2:0]       sc;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       code_q;
    logic [6:0]       botoes_q;
    logic             jogada_q;
    logic             erro_q;
    logic [2:0]       db_code_q;
    logic             qualify_done;
    logic             release_done;

    sync_2ff #(
        .W (4)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   ({ard_valid, ard_code}),
        .q_o   (sync_out)
    );

    assign sv = sync_out[3];
    assign sc = sync_out[2:0];

    // Qualification finishes when the code has been unchanged for the full window.
    assign qualify_done = (state_q == ST_QUALIFY) && sv && (sc == code_q) && (cnt_q == STABLE_LAST);
    // The link is released only once the Arduino drops valid.
    assign release_done = (state_q == ST_RELEASE) && !sv;

    // Main FSM with shared counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            code_q    <= NOTE_NONE;
            botoes_q  <= '0;
            jogada_q  <= 1'b0;
            erro_q    <= 1'b0;
            db_code_q <= NOTE_NONE;
        end else if (!enable) begin
            // Disabled: park in IDLE and silence outputs; db_code keeps the last note.
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            botoes_q  <= '0;
            jogada_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            jogada_q <= 1'b0;
            erro_q   <= 1'b0;
            botoes_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (sv) begin
                        state_q <= ST_QUALIFY;
                        code_q  <= sc;
                        cnt_q   <= '0;
                    end
                end
                ST_QUALIFY: begin
                    if (!sv) begin
                        state_q <= ST_IDLE;
                    end else if (sc != code_q) begin
                        // Code moved: restart the stability window on the new value.
                        code_q <= sc;
                        cnt_q  <= '0;
                    end else if (qualify_done) begin
                        state_q <= (code_q != NOTE_NONE) ? ST_EMIT : ST_ERRO;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_EMIT: begin
                    jogada_q  <= 1'b1;
                    botoes_q  <= onehot7(code_q);
                    db_code_q <= code_q;
                    cnt_q     <= '0;
                    state_q   <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Link activity is ignored while the note is being held.
                    botoes_q <= onehot7(code_q);
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (release_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERRO: begin
                    erro_q  <= 1'b1;
                    state_q <= ST_RELEASE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ARDUINO_ACK_EN
    logic ack_q;

    // Acknowledge from EMIT/ERRO entry until the edge that leaves RELEASE.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ack_q <= 1'b0;
        end else if (!enable) begin
            ack_q <= 1'b0;
        end else if (qualify_done) begin
            ack_q <= 1'b1;
        end else if (release_done) begin
            ack_q <= 1'b0;
        end
    end

    assign ard_ack = ack_q;
`endif

    assign botoes      = botoes_q;
    assign jogada      = jogada_q;
    assign erro_codigo = erro_q;
    assign db_code     = db_code_q;
    assign db_estado   = state_q;

endmodule
